// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the RV32I instruction fetch
//               stage (NOP encoding, fetch FSM states, default reset PC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // addi x0, x0, 0 : canonical RV32I NOP, used for every pipeline bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // one request outstanding
    ST_KILL = 2'd2,  // outstanding response will be dropped
    ST_HALT = 2'd3   // misaligned-fetch trap pending
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : One-entry holding buffer for a fetched instruction that
//               could not enter IF/ID because IF/ID was stalled.
//               Clear has priority over write, write over read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [XLEN-1:0] wr_instr_i,
  input  logic            rd_i,
  input  logic            clr_i,
  output logic            buf_valid_o,
  output logic [XLEN-1:0] buf_pc_o,
  output logic [XLEN-1:0] buf_instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Next-state of the entry: clear beats write beats read (read empties it)
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      pc_d    = wr_pc_i;
      instr_d = wr_instr_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign buf_valid_o = valid_q;
  assign buf_pc_o    = pc_q;
  assign buf_instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage. Owns the PC, keeps at most one
//               request outstanding to instruction memory, and drives the
//               IF/ID pipeline register under stall/flush/redirect control.
//               Optional feature macro: FETCH_MISALIGN_CHK_EN - when defined,
//               a redirect to a non word-aligned target halts fetch and
//               delivers a misaligned-fetch exception through IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_write,
  input  logic            IF_ID_write,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_exc
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            ifv_q, ifv_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] ifinstr_q, ifinstr_d;

  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;
  logic            buf_wr;
  logic            buf_rd;

  logic            kill;
  logic            accept;
  logic            resp;
  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_CHK_EN
  logic            misalign;
  logic            exc_q, exc_d;
  logic            exc_pend_q, exc_pend_d;

  // Misaligned targets are kept verbatim so the trap can report them
  assign target   = redirect_pc;
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign if_id_exc = exc_q;
`else
  // Without the check, low address bits are simply ignored
  assign target    = redirect_pc & ALIGN_MASK;
  assign if_id_exc = 1'b0;
`endif

  // Redirect implies flush; both squash the in-flight fetch and IF/ID
  assign kill   = redirect_valid || flush;
  assign imem_req = (state_q == ST_IDLE) && !buf_valid && PC_write &&
                    !redirect_valid && !flush && !rst;
  assign imem_addr = pc_q;
  assign accept = imem_req && imem_ready;
  assign resp   = (state_q == ST_WAIT) && imem_rvalid;

  // A surviving response goes to the buffer unless IF/ID can take it directly
  assign buf_wr = resp && !kill && !(IF_ID_write && !buf_valid);
  assign buf_rd = IF_ID_write && buf_valid && !kill;

  fetch_buf #(
    .XLEN (XLEN)
  ) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_i        (buf_wr),
    .wr_pc_i     (req_pc_q),
    .wr_instr_i  (imem_rdata),
    .rd_i        (buf_rd),
    .clr_i       (kill),
    .buf_valid_o (buf_valid),
    .buf_pc_o    (buf_pc),
    .buf_instr_o (buf_instr)
  );

  // Fetch FSM next-state: track the single outstanding request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)         state_d = ST_WAIT;
      ST_WAIT: if (imem_rvalid)    state_d = ST_IDLE;
               else if (kill)      state_d = ST_KILL;
      ST_KILL: if (imem_rvalid)    state_d = ST_IDLE;
      ST_HALT: if (redirect_valid) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    if (misalign) state_d = ST_HALT;
`endif
  end

  // PC next-state: redirect overrides everything, stalls do not block it
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = target;
    end else if (accept) begin
      pc_d = pc_q + PC_STEP;
    end
    if (accept) req_pc_d = pc_q;
  end

  // IF/ID next-state: bubble on kill, else buffer > response > bubble
  always_comb begin
    ifv_d     = ifv_q;
    ifpc_d    = ifpc_q;
    ifinstr_d = ifinstr_q;
`ifdef FETCH_MISALIGN_CHK_EN
    exc_d      = exc_q;
    exc_pend_d = exc_pend_q;
    if (redirect_valid) exc_pend_d = misalign;
`endif
    if (kill) begin
      ifv_d     = 1'b0;
      ifinstr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
      exc_d     = 1'b0;
`endif
    end else if (IF_ID_write) begin
      ifv_d     = 1'b0;
      ifinstr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
      exc_d     = 1'b0;
`endif
      if (buf_valid) begin
        ifv_d     = 1'b1;
        ifpc_d    = buf_pc;
        ifinstr_d = buf_instr;
      end else if (resp) begin
        ifv_d     = 1'b1;
        ifpc_d    = req_pc_q;
        ifinstr_d = imem_rdata;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      // Trap is delivered once; the PC still holds the faulting target
      if (exc_pend_q) begin
        ifv_d      = 1'b1;
        ifpc_d     = pc_q;
        ifinstr_d  = NOP_INSTR;
        exc_d      = 1'b1;
        exc_pend_d = 1'b0;
      end
`endif
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      ifv_q     <= 1'b0;
      ifpc_q    <= '0;
      ifinstr_q <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      ifv_q     <= ifv_d;
      ifpc_q    <= ifpc_d;
      ifinstr_q <= ifinstr_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Exception flag and pending-trap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q      <= 1'b0;
      exc_pend_q <= 1'b0;
    end else begin
      exc_q      <= exc_d;
      exc_pend_q <= exc_pend_d;
    end
  end
`endif

  assign if_id_valid    = ifv_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_instr    = ifinstr_q;
  assign if_id_pc_plus4 = ifpc_q + PC_STEP;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. Memory
//               responses are driven by hand, one step per clock cycle.
//               Honours FETCH_MISALIGN_CHK_EN for the misaligned redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] IS  = 32'h0050_0093;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] I4  = 32'h0060_0313;

  logic        clk;
  logic        rst;
  logic        PC_write;
  logic        IF_ID_write;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_exc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_exc      (if_id_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(if_id_valid), 32'(v));
    check({tag, "_pc"},    if_id_pc,    pc);
    check({tag, "_instr"}, if_id_instr, instr);
  endtask

  initial begin
    rst = 1'b1; PC_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check_ifid("rst", 1'b0, 32'h0, NOP);
    check("rst_plus4", if_id_pc_plus4, 32'h4);
    check("rst_exc", 32'(if_id_exc), 32'd0);

    // First request right after reset release, at RESET_PC
    rst = 1'b0; #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = I0; #1;
    check("wait_noreq", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("f0", 1'b1, 32'h0, I0);
    check("f0_plus4", if_id_pc_plus4, 32'h4);
    check("f1_addr", imem_addr, 32'h4);
    check("f1_req", 32'(imem_req), 32'd1);
    tick();
    imem_rvalid = 1'b1; imem_rdata = I1; #1;
    check("gap_valid", 32'(if_id_valid), 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("f1", 1'b1, 32'h4, I1);
    check("f2_addr", imem_addr, 32'h8);
    tick();
    imem_rvalid = 1'b1; imem_rdata = I2;
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("f2", 1'b1, 32'h8, I2);
    check("f3_addr", imem_addr, 32'hC);
    check("f3_req", 32'(imem_req), 32'd1);
    tick();

    // Stall while the response for 0xC returns: goes into the buffer
    IF_ID_write = 1'b0; PC_write = 1'b0; imem_rvalid = 1'b1; imem_rdata = IS; #1;
    check("stall_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    check("stall_req2", 32'(imem_req), 32'd0);
    check("stall_hold", 32'(if_id_valid), 32'd0);
    tick();
    PC_write = 1'b1; #1;
    check("buf_blocks_req", 32'(imem_req), 32'd0);
    tick();
    IF_ID_write = 1'b1; #1;
    tick();
    check_ifid("release", 1'b1, 32'hC, IS);
    check("after_buf_req", 32'(imem_req), 32'd1);
    check("after_buf_addr", imem_addr, 32'h10);
    tick();

    // Redirect while WAIT: response dropped via KILL
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("redir_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("kill_valid", 32'(if_id_valid), 32'd0);
    check("kill_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    check("kill_drop_valid", 32'(if_id_valid), 32'd0);
    check("kill_drop_instr", if_id_instr, NOP);
    check("redir_req2", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    tick();
    imem_rvalid = 1'b1; imem_rdata = I3;
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("f100", 1'b1, 32'h100, I3);
    check("f104_addr", imem_addr, 32'h104);
    tick();

    // Flush coinciding with the response
    flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    flush = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0; #1;
    check("flush_valid", 32'(if_id_valid), 32'd0);
    check("flush_instr", if_id_instr, NOP);
    check("flush_req", 32'(imem_req), 32'd1);
    check("flush_addr", imem_addr, 32'h108);
    tick();

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0; #1;
`ifdef FETCH_MISALIGN_CHK_EN
    check("halt_req", 32'(imem_req), 32'd0);
    tick();
    check("mis_exc", 32'(if_id_exc), 32'd1);
    check_ifid("mis", 1'b1, 32'h102, NOP);
    check("halt_req2", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    check("halt_exit_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    check("halt_exit_req2", 32'(imem_req), 32'd1);
    check("halt_exit_addr", imem_addr, 32'h200);
`else
    check("mis_req", 32'(imem_req), 32'd1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_exc", 32'(if_id_exc), 32'd0);
`endif

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; #1;
    check("top_req", 32'(imem_req), 32'd1);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = I4;
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("top", 1'b1, 32'hFFFF_FFFC, I4);
    check("top_plus4", if_id_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    tick();

    // Reset with a request outstanding; late response must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("rr_req", 32'(imem_req), 32'd1);
    check("rr_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0; #1;
    check_ifid("rr", 1'b0, 32'h0, NOP);
    check("rr_req2", 32'(imem_req), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
